nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_pkg.sv | 26 ++
 rtl/nibble_serial_adder_add4_slice.sv | 42 ++++
 rtl/nibble_serial_adder.sv | 214 +++++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_pkg
// Shared types and constants for the digit-serial nibble adder.
//   state_e    : control state of the serial adder (IDLE, RUN, DONE)
//   NIBBLE     : width of the reused adder slice, in bits
//   cnt_width(): width of the nibble index counter for a given operand width
// -----------------------------------------------------------------------------
package nibble_serial_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index width/NIBBLE nibbles; never less than one bit so
  // the counter is always a real vector.
  function automatic int cnt_width(input int width);
    int nibs;
    nibs = width / NIBBLE;
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage : nibble_serial_pkg

// File: rtl/nibble_serial_adder_add4_slice.sv
// -----------------------------------------------------------------------------
// add4_slice
// Combinational 4-bit ripple-carry adder slice.
//   x, y : nibble operands
//   ci   : carry into bit 0
//   s    : nibble sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (only with NIBBLE_SERIAL_OVF_EN; used to form
//          signed overflow as c3 ^ co)
// Optional feature macro: NIBBLE_SERIAL_OVF_EN
// -----------------------------------------------------------------------------
module add4_slice
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE-1:0] x,
  input  logic [NIBBLE-1:0] y,
  input  logic              ci,
  output logic [NIBBLE-1:0] s,
`ifdef NIBBLE_SERIAL_OVF_EN
  output logic              c3,
`endif
  output logic              co
);

  // c[i] is the carry into bit i; c[NIBBLE] is the slice carry-out.
  logic [NIBBLE:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < NIBBLE; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[NIBBLE];

`ifdef NIBBLE_SERIAL_OVF_EN
  assign c3 = c[NIBBLE-1];
`endif

endmodule : add4_slice

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in one nibble per
// clock through a single 4-bit ripple slice, then presents the registered
// result on a valid/ready output handshake.
//
// Parameters
//   WIDTH     : operand / sum width (multiple of 4, >= 8)
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active-high
//   in_valid  : operand set offered
//   in_ready  : block can accept operands (high only in IDLE)
//   a, b, cin : operands and carry-in, captured on accept
//   out_valid : result available (high only in DONE)
//   out_ready : consumer accepts result
//   sum       : registered sum, a+b+cin modulo 2^WIDTH
//   ovf       : signed overflow of the addition (NIBBLE_SERIAL_OVF_EN only)
//   cout      : registered carry out of the most-significant nibble
// Optional feature macro: NIBBLE_SERIAL_OVF_EN
//
// Timing: accept edge, then WIDTH/4 RUN cycles, then DONE; a result is
// offered WIDTH/4+1 cycles after the accept cycle begins, and with out_ready
// held high a new operand set is taken every WIDTH/4+2 cycles.
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIBS  = WIDTH / NIBBLE;
  localparam int CNT_W = cnt_width(WIDTH);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
    $fatal(1, "nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // ---------------------------------------------------------------------------
  // Adder slice and nibble select
  // ---------------------------------------------------------------------------
  logic [NIBBLE-1:0]  slice_x;
  logic [NIBBLE-1:0]  slice_y;
  logic [NIBBLE-1:0]  slice_s;
  logic               slice_co;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic               slice_c3;
`endif
  logic               last_nib;

  // Mux the current nibble of each captured operand onto the slice.
  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (idx_q == CNT_W'(i)) begin
        slice_x = a_q[i*NIBBLE +: NIBBLE];
        slice_y = b_q[i*NIBBLE +: NIBBLE];
      end
    end
  end

  add4_slice u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
`ifdef NIBBLE_SERIAL_OVF_EN
    .c3 (slice_c3),
`endif
    .co (slice_co)
  );

  assign last_nib = (idx_q == CNT_W'(NIBS - 1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBS; i++) begin
          if (idx_q == CNT_W'(i)) begin
            sum_d[i*NIBBLE +: NIBBLE] = slice_s;
          end
        end
        carry_d = slice_co;
        if (last_nib) begin
          // Counter parks on the last index rather than wrapping.
          cout_d  = slice_co;
`ifdef NIBBLE_SERIAL_OVF_EN
          ovf_d   = slice_c3 ^ slice_co;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Result held stable until the consumer takes it.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  // NOTE: the operand and carry registers are reset as well; they are small
  // flops, not a memory, and clearing them keeps the block fully defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder (WIDTH=16). A transaction-level
// model predicts handshake availability and the arithmetic result; a compare
// process checks the DUT against it on every falling edge, and directed cases
// pin literal results, latency and throughput.
// Optional feature macro: NIBBLE_SERIAL_OVF_EN (checks ovf when defined)
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int W    = 16;
  localparam int NIBS = W / 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NIBBLE_SERIAL_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a busy window of NIBS cycles after each accept, then a
  // result held until out_ready; result is plain integer arithmetic.
  // ---------------------------------------------------------------------------
  logic         m_busy;
  int           m_left;
  logic         m_valid;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_left  = 0;
      m_valid = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
      end
    end else if (in_valid) begin
      logic [W:0] full;
      int         s_signed;
      full     = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      m_sum    = full[W-1:0];
      m_cout   = full[W];
      s_signed = int'($signed(a)) + int'($signed(b)) + int'(cin);
      m_ovf    = (s_signed > (2**(W-1) - 1)) || (s_signed < -(2**(W-1)));
      m_busy   = 1'b1;
      m_left   = NIBS;
    end
  end

  // Compare process: reset values while rst is high, otherwise the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
`ifdef NIBBLE_SERIAL_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
    end else begin
      check("in_ready", in_ready, !(m_busy || m_valid));
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("sum", sum, m_sum);
        check("cout", cout, m_cout);
`ifdef NIBBLE_SERIAL_OVF_EN
        check("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int t_acc;

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1 t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
    lat = cyc - t_acc + 1;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int acc[3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic add, latency pinned.
    send(16'h1234, 16'h4321, 1'b0);
    wait_result(lat);
    check("lat_1234", lat, NIBS + 1);
    check("sum_1234", sum, 16'h5555);
    check("cout_1234", cout, 0);
    take();

    // Full carry ripple through every nibble.
    send(16'hFFFF, 16'h0000, 1'b1);
    wait_result(lat);
    check("sum_ffff", sum, 16'h0000);
    check("cout_ffff", cout, 1);
    take();

    // Signed overflow corners.
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_result(lat);
    check("sum_7fff", sum, 16'h8000);
    check("cout_7fff", cout, 0);
`ifdef NIBBLE_SERIAL_OVF_EN
    check("ovf_7fff", ovf, 1);
`endif
    take();
    send(16'h8000, 16'h8000, 1'b0);
    wait_result(lat);
    check("sum_8000", sum, 16'h0000);
    check("cout_8000", cout, 1);
`ifdef NIBBLE_SERIAL_OVF_EN
    check("ovf_8000", ovf, 1);
`endif
    take();

    // Backpressure: result held, pulsed in_valid ignored.
    send(16'h0F0F, 16'h00F1, 1'b0);
    wait_result(lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 16'h1000);
      if (k == 4) begin
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
      end else begin
        in_valid = 1'b0;
      end
    end
    take();
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);

    // Reset in the middle of RUN after two nibbles.
    send(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(16'h0001, 16'h0001, 1'b0);
    wait_result(lat);
    check("post_rst_sum", sum, 16'h0002);
    take();

    // Random single transactions with random consumer delay.
    for (int k = 0; k < 16; k++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      wait_result(lat);
      check("rand_lat", lat, NIBS + 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take();
    end

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int guard;
      guard = 0;
      while ((m_busy || m_valid) && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk);
      #1 acc[k] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_period_1", acc[1] - acc[0], NIBS + 2);
    check("b2b_period_2", acc[2] - acc[1], NIBS + 2);
    repeat (NIBS + 3) @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit in case a wait goes astray.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_nibble_serial_adder
